// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback stage wrapped around an external combinational ALU.
// Optional macro ALU_FWD_EN forwards alu_out to ISS hazards whose condition is AL.
module alu_issue_wb #(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [AW-1:0] in_rd,
    output logic [31:0]   alu_r1,
    output logic [31:0]   alu_r2,
    output logic [31:0]   alu_instr,
    input  logic [32:0]   alu_out,
    input  logic [3:0]    alu_flg,
    output logic          wb_we,
    output logic [AW-1:0] wb_rd,
    output logic [31:0]   wb_data,
    output logic [3:0]    flags
);
    logic [31:0]   rf [NREG];
    logic          iss_valid, wb_valid, wb_sf;
    logic [AW-1:0] iss_rd, wb_dst;
    logic [3:0]    wb_cond, wb_op, wb_flg;
    logic [31:0]   wb_res, rd1, rd2;
    logic          n, z, c, v, cond_ok, commit, flag_we;
    logic          haz1, haz2, fwd, stall, accept, unused_msb;

    assign unused_msb = alu_out[32];
    assign {n, z, c, v} = flags;

    always_comb begin
        case (wb_cond)
            4'h0: cond_ok = z;
            4'h1: cond_ok = !z;
            4'h2: cond_ok = c;
            4'h3: cond_ok = !c;
            4'h4: cond_ok = n;
            4'h5: cond_ok = !n;
            4'h6: cond_ok = v;
            4'h7: cond_ok = !v;
            4'h8: cond_ok = c & !z;
            4'h9: cond_ok = !c | z;
            4'hA: cond_ok = n == v;
            4'hB: cond_ok = n != v;
            4'hC: cond_ok = !z & (n == v);
            4'hD: cond_ok = z | (n != v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign commit  = wb_valid & cond_ok;
    assign wb_we   = commit & (wb_op != 4'h8);
    assign flag_we = commit & (wb_sf | (wb_op == 4'h8));
    assign wb_rd   = wb_we ? wb_dst : '0;
    assign wb_data = wb_we ? wb_res : '0;

    // Compares never write rd, so they cannot create a RAW hazard.
    assign haz1 = iss_valid & (alu_instr[27:24] != 4'h8) & (iss_rd == in_rs1);
    assign haz2 = iss_valid & (alu_instr[27:24] != 4'h8) & (iss_rd == in_rs2);
`ifdef ALU_FWD_EN
    assign fwd = alu_instr[31:28] == 4'hE;
`else
    assign fwd = 1'b0;
`endif
    assign stall    = (haz1 | haz2) & !fwd;
    assign in_ready = !rst & !stall;
    assign accept   = in_valid & in_ready;

    assign rd1 = (haz1 & fwd) ? alu_out[31:0] : (wb_we && wb_dst == in_rs1) ? wb_res : rf[in_rs1];
    assign rd2 = (haz2 & fwd) ? alu_out[31:0] : (wb_we && wb_dst == in_rs2) ? wb_res : rf[in_rs2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_rd    <= '0;
            alu_r1    <= '0;
            alu_r2    <= '0;
            alu_instr <= '0;
            wb_valid  <= 1'b0;
            wb_dst    <= '0;
            wb_cond   <= '0;
            wb_op     <= '0;
            wb_sf     <= 1'b0;
            wb_res    <= '0;
            wb_flg    <= '0;
            flags     <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            iss_valid <= accept;
            iss_rd    <= accept ? in_rd : '0;
            alu_r1    <= accept ? rd1 : '0;
            alu_r2    <= accept ? rd2 : '0;
            alu_instr <= accept ? in_instr : '0;
            wb_valid  <= iss_valid;
            wb_dst    <= iss_rd;
            wb_cond   <= alu_instr[31:28];
            wb_op     <= alu_instr[27:24];
            wb_sf     <= alu_instr[23];
            wb_res    <= alu_out[31:0];
            wb_flg    <= alu_flg;
            if (wb_we) rf[wb_dst] <= wb_res;
            if (flag_we) flags <= wb_flg;
        end
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed and random stream checked against an in-order architectural model.
module tb_alu_issue_wb;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_we;
    logic [31:0] in_instr, alu_r1, alu_r2, alu_instr, wb_data;
    logic [3:0]  in_rs1, in_rs2, in_rd, wb_rd, alu_flg, flags;
    logic [32:0] alu_out;

`ifdef ALU_FWD_EN
    localparam int EXP_STALL = 0;
    localparam int EXP_GAP   = 1;
`else
    localparam int EXP_STALL = 1;
    localparam int EXP_GAP   = 2;
`endif

    int n_chk = 0, n_fail = 0, cyc = 0, n_commit = 0, last_cc = 0, prev_cc = 0;
    logic [31:0] m_rf [16];
    logic [3:0]  m_flg;
    logic [35:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_issue_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .alu_r1(alu_r1), .alu_r2(alu_r2),
        .alu_instr(alu_instr), .alu_out(alu_out), .alu_flg(alu_flg), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags)
    );

    // Simple ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV imm, 8 CMP; returns {flags, out}.
    function automatic logic [36:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins);
        logic [32:0] s;
        logic cf, vf;
        cf = 1'b0;
        vf = 1'b0;
        case (ins[27:24])
            4'h0: begin s = {1'b0, a} + {1'b0, b}; cf = s[32]; vf = (a[31] == b[31]) && (s[31] != a[31]); end
            4'h1, 4'h8: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; cf = s[32]; vf = (a[31] != b[31]) && (s[31] != a[31]); end
            4'h2: s = {1'b0, a & b};
            4'h3: s = {1'b0, a | b};
            4'h4: s = {1'b0, a ^ b};
            4'h5: s = {17'b0, ins[18:3]};
            default: s = '0;
        endcase
        return {s[31], s[31:0] == 32'd0, cf, vf, s};
    endfunction

    assign {alu_flg, alu_out} = alu_f(alu_r1, alu_r2, alu_instr);

    function automatic logic pass(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            0: return fz;          1: return !fz;
            2: return fc;          3: return !fc;
            4: return fn;          5: return !fn;
            6: return fv;          7: return !fv;
            8: return fc && !fz;   9: return !fc || fz;
            10: return fn == fv;   11: return fn != fv;
            12: return !fz && fn == fv;
            13: return fz || fn != fv;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            n_commit++;
            prev_cc = last_cc;
            last_cc = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL commit_unexpected: observed rd %0d data %0h expected no commit", wb_rd, wb_data);
            end else chk("commit", {28'b0, wb_rd, wb_data}, {28'b0, exp_q.pop_front()});
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, output int stalls);
        logic [36:0] r;
        logic [31:0] ea, eb;
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_rs1 = a; in_rs2 = b; in_rd = d;
        #1;
        while (!in_ready && stalls < 8) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $error("FAIL issue_timeout: observed in_ready 0 expected 1 within 8 cycles");
            in_valid = 1'b0;
            return;
        end
        ea = m_rf[a];
        eb = m_rf[b];
        r = alu_f(ea, eb, ins);
        if (pass(ins[31:28], m_flg)) begin
            if (ins[27:24] != 4'h8) begin
                m_rf[d] = r[31:0];
                exp_q.push_back({d, r[31:0]});
            end
            if (ins[23] || ins[27:24] == 4'h8) m_flg = r[36:33];
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("alu_r1", alu_r1, ea);
        chk("alu_r2", alu_r2, eb);
        chk("alu_instr", alu_instr, ins);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mov(input logic [3:0] d, input logic [15:0] val);
        int s;
        issue(32'hE5000000 | {13'b0, val, 3'b0}, 4'd0, 4'd0, d, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c0;
        logic [3:0] f0;
        logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8};
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_flg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_flags", flags, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_alu_instr", alu_instr, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);

        mov(1, 5);
        mov(2, 3);
        idle(4);
        issue(32'hE0000000, 1, 2, 3, s);
        issue(32'hE0000000, 3, 1, 4, s);
        chk("dep_stall", s, EXP_STALL);
        idle(4);
        chk("dep_commit_gap", last_cc - prev_cc, EXP_GAP);
        chk("dep_r4_data", wb_data, 0);

        c0 = n_commit;
        issue(32'hE8000000, 1, 1, 0, s);
        idle(4);
        chk("cmp_no_write", n_commit, c0);
        chk("cmp_z", flags[2], 1);
        issue(32'h00000000, 1, 2, 5, s);
        idle(4);
        chk("eq_write", n_commit, c0 + 1);
        issue(32'h10000000, 1, 2, 6, s);
        idle(4);
        chk("ne_no_write", n_commit, c0 + 1);

        f0 = flags;
        issue(32'hF0800000, 1, 2, 7, s);
        idle(4);
        chk("nv_no_write", n_commit, c0 + 1);
        chk("nv_flags_held", flags, f0);

        mov(3, 1);
        idle(4);
        issue(32'hE0000000, 1, 2, 3, s);
        issue(32'hE0000000, 1, 1, 8, s);
        issue(32'hE0000000, 3, 0, 9, s);
        chk("wt_no_stall", s, 0);
        chk("wt_r1", alu_r1, 8);
        idle(4);
        chk("flags_directed", flags, m_flg);

        for (int k = 0; k < 60; k++) begin
            logic [3:0] cc;
            cc = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            issue({cc, ops[$urandom_range(0, 6)], 1'($urandom), 4'b0, 16'($urandom), 3'b0},
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), s);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(5);
        chk("rand_flags", flags, m_flg);
        chk("rand_queue_drained", exp_q.size(), 0);

        issue(32'hE0000000, 1, 2, 10, s);
        issue(32'hE0000000, 2, 2, 11, s);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", in_ready, 0);
        chk("midrst_alu_r1", alu_r1, 0);
        chk("midrst_alu_instr", alu_instr, 0);
        chk("midrst_wb", {wb_we, wb_rd, wb_data}, 0);
        chk("midrst_flags", flags, 0);
        c0 = n_commit;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_flg = '0;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        idle(4);
        chk("midrst_no_commit", n_commit, c0);
        issue(32'hE0000000, 1, 2, 12, s);
        chk("midrst_rf_zero", alu_r2, 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
